jtframe_dwnld_banks: RTL and testbench
======================================

JTFRAME_DWNLD_BANKS -- requirements
Module: jtframe_dwnld_banks

Interface
REQ-001 Parameter SDRAMW, default 22, SDRAM word-address width.
REQ-002 Parameter BANKS, default 4, number of SDRAM banks used, range 1..4.
REQ-003 Parameter BA1_START / BA2_START / BA3_START, default 25'h40_0000 / 25'h80_0000 / 25'hC0_0000, byte offsets where banks 1..3 begin.
REQ-004 Parameter DEPTH, default 4, write-FIFO entries, power of 2, minimum 2.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 downloading  in  1  high while the ROM download is in progress.
REQ-008 ioctl_addr  in  25  byte address of the downloaded byte.
REQ-009 ioctl_dout  in  8  downloaded byte.
REQ-010 ioctl_wr  in  1  one-cycle strobe; byte valid.
REQ-011 prog_addr  out  SDRAMW  word address within the selected bank.
REQ-012 prog_data  out  16  downloaded byte replicated on both lanes.
REQ-013 prog_mask  out  2  active-low byte-lane enable.
REQ-014 prog_ba  out  2  target bank.
REQ-015 prog_we  out  1  write request to SDRAM controller.
REQ-016 prog_rdy  in  1  one-cycle pulse; request completed.
REQ-017 dwnld_busy  out  1  download or drain still in progress.
REQ-018 ovf  out  1  sticky FIFO-overflow flag.

Function
REQ-019 Bank select: highest bank b < BANKS with ioctl_addr >= BAb_START wins; else bank 0; BANKS=1 always bank 0.
REQ-020 Entry word address = (ioctl_addr - start of selected bank) >> 1, truncated to SDRAMW bits.
REQ-021 ioctl_addr[0]=0 -> prog_mask 2'b10 (low byte); ioctl_addr[0]=1 -> prog_mask 2'b01 (high byte).
REQ-022 Each ioctl_wr pushes {ba, addr, mask, byte} into the FIFO on the same edge; wr pointer wraps modulo DEPTH.
REQ-023 FSM states IDLE, ISSUE, GAP.
REQ-024 IDLE: FIFO non-empty -> load head onto prog_* outputs, assert prog_we, go ISSUE next cycle.
REQ-025 ISSUE: prog_we and prog_* outputs held stable until prog_rdy; on prog_rdy deassert prog_we, pop head, go GAP.
REQ-026 GAP: one cycle with prog_we low, then IDLE; minimum spacing between requests is therefore 2 idle-low cycles after each rdy.
REQ-027 Latency ioctl_wr to prog_we high: 2 cycles with empty FIFO and FSM in IDLE.
REQ-028 Push and pop on the same edge allowed; occupancy unchanged.
REQ-029 ioctl_wr while FIFO full and no pop that edge: byte discarded, ovf set.
REQ-030 ovf cleared on the rising edge of downloading; otherwise held.
REQ-031 prog_rdy outside ISSUE ignored.
REQ-032 Falling downloading with FIFO non-empty: FIFO keeps draining; no entries dropped.
REQ-033 dwnld_busy = downloading OR FIFO non-empty OR FSM not IDLE.

Reset
REQ-034 rst_n low: FSM IDLE, FIFO empty, pointers 0, prog_we 0, prog_addr 0, prog_data 0, prog_mask 2'b11, prog_ba 0, ovf 0, dwnld_busy follows downloading only.
REQ-035 Reset during ISSUE aborts the request; pending entries lost, no further prog_we until new ioctl_wr.

Configuration
REQ-036 Macro JTFRAME_DWNLD_PROM_EN defined: adds parameter PROM_START (default 25'h1F0_0000) and outputs prom_we (1) and prom_addr (10); bytes at ioctl_addr >= PROM_START bypass the FIFO, pulse prom_we one cycle after ioctl_wr with prom_addr = ioctl_addr - PROM_START [9:0], and reuse ioctl_dout.
REQ-037 Macro undefined: ports and parameter absent; every byte goes to SDRAM.

Structure
REQ-038 Package jtframe_dwnld_pkg holds FSM state enum, FIFO entry struct and default bank-start constants.
REQ-039 One sub-module, jtframe_dwnld_fifo (DEPTH-entry synchronous FIFO, full/empty flags).

Verification
REQ-040 Byte 8'hA5 at ioctl_addr 25'h00_0003 -> prog_we 2 cycles later, prog_ba 0, prog_addr 1, prog_mask 2'b01, prog_data 16'hA5A5.
REQ-041 ioctl_addr 25'h80_0004, BANKS=4 -> prog_ba 2, prog_addr 2, mask 2'b10; with BANKS=2 -> prog_ba 1, prog_addr 25'h20_0002.
REQ-042 prog_rdy withheld, 5 ioctl_wr with DEPTH=4 -> fifth byte dropped, ovf=1; subsequent rdy pulses emit exactly 4 writes in order; ovf clears at next downloading rise.
REQ-043 downloading falls with 3 entries queued -> dwnld_busy stays high until third prog_rdy plus GAP, then low.
REQ-044 rst_n pulsed low during ISSUE -> prog_we 0 immediately, FIFO empty, ovf 0.
REQ-045 JTFRAME_DWNLD_PROM_EN defined, ioctl_addr 25'h1F0_0010 -> prom_we pulse, prom_addr 10'h010, no prog_we.

Source files
------------

// File: rtl/jtframe_dwnld_pkg.sv
// rtl/jtframe_dwnld_pkg.sv - shared types and defaults for the banked ROM download path
package jtframe_dwnld_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Word addresses are kept at full 24-bit width and trimmed to SDRAMW at the output.
   localparam int ENTRY_AW = 24;

   localparam logic [24:0] BA1_START_DEF = 25'h040_0000;
   localparam logic [24:0] BA2_START_DEF = 25'h080_0000;
   localparam logic [24:0] BA3_START_DEF = 25'h0C0_0000;

   typedef struct packed {
      logic [1:0]          ba;
      logic [ENTRY_AW-1:0] addr;
      logic [1:0]          mask;
      logic [7:0]          data;
   } entry_t;

   function automatic logic [1:0] lane_mask(input logic odd);
      return odd ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/jtframe_dwnld_banks_if.sv
// rtl/jtframe_dwnld_banks_if.sv - SDRAM programming request bus
interface jtframe_dwnld_banks_if #(
   parameter int SDRAMW = 22
);
   logic [SDRAMW-1:0] prog_addr;
   logic [15:0]       prog_data;
   logic [1:0]        prog_mask;
   logic [1:0]        prog_ba;
   logic              prog_we;
   logic              prog_rdy;

   modport master (
      output prog_addr, prog_data, prog_mask, prog_ba, prog_we,
      input  prog_rdy
   );

   modport slave (
      input  prog_addr, prog_data, prog_mask, prog_ba, prog_we,
      output prog_rdy
   );
endinterface

// File: rtl/jtframe_dwnld_fifo.sv
// rtl/jtframe_dwnld_fifo.sv - DEPTH-entry synchronous FIFO of pending SDRAM byte writes
module jtframe_dwnld_fifo
   import jtframe_dwnld_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  logic   pop,
   input  entry_t din,
   output entry_t dout,
   output logic   full,
   output logic   empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   // A pop on the same edge frees the slot the push needs.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/jtframe_dwnld_banks.sv
// rtl/jtframe_dwnld_banks.sv - queues downloaded bytes and writes them into SDRAM banks; JTFRAME_DWNLD_PROM_EN adds a PROM bypass port
module jtframe_dwnld_banks
   import jtframe_dwnld_pkg::*;
#(
   parameter int          SDRAMW    = 22,
   parameter int          BANKS     = 4,
   parameter logic [24:0] BA1_START = BA1_START_DEF,
   parameter logic [24:0] BA2_START = BA2_START_DEF,
   parameter logic [24:0] BA3_START = BA3_START_DEF,
   parameter int          DEPTH     = 4
`ifdef JTFRAME_DWNLD_PROM_EN
   ,
   parameter logic [24:0] PROM_START = 25'h1F0_0000
`endif
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        downloading,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        ioctl_wr,
   jtframe_dwnld_banks_if.master prog,
   output logic        dwnld_busy,
   output logic        ovf
`ifdef JTFRAME_DWNLD_PROM_EN
   ,
   output logic        prom_we,
   output logic [9:0]  prom_addr
`endif
);

   state_t              state;
   entry_t              new_entry;
   entry_t              head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic                drop;
   logic                is_prom;
   logic                downloading_d;
   logic [1:0]          sel_ba;
   logic [ENTRY_AW-1:0] sel_start;
   logic                unused_addr_bits;

   // Later banks override earlier ones, so the highest matching start wins.
   always_comb begin
      sel_ba    = 2'd0;
      sel_start = '0;
      if (BANKS > 1 && ioctl_addr >= BA1_START) begin
         sel_ba    = 2'd1;
         sel_start = BA1_START[24:1];
      end
      if (BANKS > 2 && ioctl_addr >= BA2_START) begin
         sel_ba    = 2'd2;
         sel_start = BA2_START[24:1];
      end
      if (BANKS > 3 && ioctl_addr >= BA3_START) begin
         sel_ba    = 2'd3;
         sel_start = BA3_START[24:1];
      end
   end

   assign new_entry.ba   = sel_ba;
   assign new_entry.addr = ioctl_addr[24:1] - sel_start;
   assign new_entry.mask = lane_mask(ioctl_addr[0]);
   assign new_entry.data = ioctl_dout;

`ifdef JTFRAME_DWNLD_PROM_EN
   assign is_prom = (ioctl_addr >= PROM_START);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prom_we   <= 1'b0;
         prom_addr <= '0;
      end else begin
         prom_we <= ioctl_wr && is_prom;
         if (ioctl_wr && is_prom) prom_addr <= 10'(ioctl_addr - PROM_START);
      end
   end
`else
   assign is_prom = 1'b0;
`endif

   assign push = ioctl_wr && !is_prom;
   assign pop  = (state == ST_ISSUE) && prog.prog_rdy;
   assign drop = push && fifo_full && !pop;

   jtframe_dwnld_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (new_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign unused_addr_bits = ^head.addr;
   assign dwnld_busy = downloading || !fifo_empty || (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         downloading_d <= 1'b0;
         ovf           <= 1'b0;
      end else begin
         downloading_d <= downloading;
         if (drop)                              ovf <= 1'b1;
         else if (downloading && !downloading_d) ovf <= 1'b0;
      end
   end

   // The head stays in the FIFO until rdy so a lost request is never silently dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         prog.prog_we   <= 1'b0;
         prog.prog_addr <= '0;
         prog.prog_data <= '0;
         prog.prog_mask <= 2'b11;
         prog.prog_ba   <= 2'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  prog.prog_addr <= SDRAMW'(head.addr);
                  prog.prog_data <= {head.data, head.data};
                  prog.prog_mask <= head.mask;
                  prog.prog_ba   <= head.ba;
                  prog.prog_we   <= 1'b1;
                  state          <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (prog.prog_rdy) begin
                  prog.prog_we <= 1'b0;
                  state        <= ST_GAP;
               end
            end
            ST_GAP: begin
               state <= ST_IDLE;
            end
            default: begin
               prog.prog_we <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtframe_dwnld_banks.sv
// tb/tb_jtframe_dwnld_banks.sv - bench for jtframe_dwnld_banks with a queue-based write model
module tb_jtframe_dwnld_banks;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        downloading = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        ioctl_wr = 1'b0;
   logic        busy, ovf, busy2, ovf2;
`ifdef JTFRAME_DWNLD_PROM_EN
   logic        prom_we, prom_we2;
   logic [9:0]  prom_addr, prom_addr2;
`endif

   jtframe_dwnld_banks_if #(.SDRAMW(22)) bus ();
   jtframe_dwnld_banks_if #(.SDRAMW(22)) bus2 ();
   assign bus2.prog_rdy = bus.prog_rdy;

   always #5 clk = ~clk;

   jtframe_dwnld_banks #(.SDRAMW(22), .BANKS(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
      .prog(bus), .dwnld_busy(busy), .ovf(ovf)
`ifdef JTFRAME_DWNLD_PROM_EN
      , .prom_we(prom_we), .prom_addr(prom_addr)
`endif
   );

   jtframe_dwnld_banks #(.SDRAMW(22), .BANKS(2), .DEPTH(DEPTH)) dut2 (
      .clk(clk), .rst_n(rst_n), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
      .prog(bus2), .dwnld_busy(busy2), .ovf(ovf2)
`ifdef JTFRAME_DWNLD_PROM_EN
      , .prom_we(prom_we2), .prom_addr(prom_addr2)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [1:0]  ba4;
      logic [21:0] wa4;
      logic [1:0]  ba2;
      logic [21:0] wa2;
      logic [1:0]  mask;
      logic [7:0]  data;
   } exp_t;

   // Bank k starts at k * 4M bytes; word address is the byte offset halved.
   function automatic exp_t mk(input logic [24:0] a, input logic [7:0] d);
      exp_t e;
      int   addr = int'(a);
      int   b4 = addr / 32'h40_0000;
      int   b2;
      if (b4 > 3) b4 = 3;
      b2 = (b4 > 1) ? 1 : b4;
      e.ba4  = 2'(b4);
      e.wa4  = 22'((addr - b4 * 32'h40_0000) / 2);
      e.ba2  = 2'(b2);
      e.wa2  = 22'((addr - b2 * 32'h40_0000) / 2);
      e.mask = a[0] ? 2'b01 : 2'b10;
      e.data = d;
      return e;
   endfunction

   exp_t q[$];
   bit   issuing;
   int   cnt;
   int   last_rdy;
   bit   m_ovf;
   bit   dl_prev;

   // Rules: a queued byte is requested one edge after it is queued, never sooner
   // than two edges after the previous completion; completion frees its slot.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         issuing  = 1'b0;
         cnt      = 0;
         last_rdy = -10;
         m_ovf    = 1'b0;
         dl_prev  = 1'b0;
      end else begin
         cnt++;
         if (issuing && bus.prog_rdy) begin
            void'(q.pop_front());
            issuing  = 1'b0;
            last_rdy = cnt;
         end
         if (!issuing && q.size() > 0 && cnt - last_rdy >= 2) issuing = 1'b1;
         if (downloading && !dl_prev) m_ovf = 1'b0;
         dl_prev = downloading;
         if (ioctl_wr) begin
            if (q.size() < DEPTH) q.push_back(mk(ioctl_addr, ioctl_dout));
            else m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         logic exp_busy;
         exp_busy = downloading || q.size() != 0 || issuing || cnt == last_rdy;
         check("we",    32'(bus.prog_we),  32'(issuing));
         check("we2",   32'(bus2.prog_we), 32'(issuing));
         check("ovf",   32'(ovf),   32'(m_ovf));
         check("ovf2",  32'(ovf2),  32'(m_ovf));
         check("busy",  32'(busy),  32'(exp_busy));
         check("busy2", 32'(busy2), 32'(exp_busy));
         if (issuing && q.size() > 0) begin
            check("ba",    32'(bus.prog_ba),    32'(q[0].ba4));
            check("addr",  32'(bus.prog_addr),  32'(q[0].wa4));
            check("ba2",   32'(bus2.prog_ba),   32'(q[0].ba2));
            check("addr2", 32'(bus2.prog_addr), 32'(q[0].wa2));
            check("mask",  32'(bus.prog_mask),  32'(q[0].mask));
            check("data",  32'(bus.prog_data),  32'({q[0].data, q[0].data}));
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      step();
      ioctl_wr   = 1'b0;
   endtask

   task automatic rdy_pulse();
      bus.prog_rdy = 1'b1;
      step();
      bus.prog_rdy = 1'b0;
   endtask

   task automatic wait_we();
      for (int i = 0; i < 20 && !bus.prog_we; i++) step();
      check("wait_we", 32'(bus.prog_we), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.prog_rdy = 1'b0;
      step(2);
      check("rst_we",   32'(bus.prog_we),   32'd0);
      check("rst_mask", 32'(bus.prog_mask), 32'd3);
      check("rst_addr", 32'(bus.prog_addr), 32'd0);
      check("rst_data", 32'(bus.prog_data), 32'd0);
      check("rst_ba",   32'(bus.prog_ba),   32'd0);
      check("rst_ovf",  32'(ovf),           32'd0);
      check("rst_busy", 32'(busy),          32'd0);
      downloading = 1'b1;
      #1;
      check("rst_busy_dl", 32'(busy), 32'd1);
      rst_n = 1'b1;
      step(2);

      // Single byte at odd address in bank 0
      wr_byte(25'h00_0003, 8'hA5);
      check("lat1_we", 32'(bus.prog_we), 32'd0);
      step();
      check("lat2_we",   32'(bus.prog_we),   32'd1);
      check("lat2_ba",   32'(bus.prog_ba),   32'd0);
      check("lat2_addr", 32'(bus.prog_addr), 32'd1);
      check("lat2_mask", 32'(bus.prog_mask), 32'h1);
      check("lat2_data", 32'(bus.prog_data), 32'hA5A5);
      step(2);
      check("hold_we", 32'(bus.prog_we), 32'd1);
      rdy_pulse();
      check("rdy_we", 32'(bus.prog_we), 32'd0);
      step(2);

      // Bank mapping for BANKS=4 and BANKS=2
      wr_byte(25'h80_0004, 8'h3C);
      step();
      check("b4_ba",   32'(bus.prog_ba),    32'd2);
      check("b4_addr", 32'(bus.prog_addr),  32'd2);
      check("b4_mask", 32'(bus.prog_mask),  32'h2);
      check("b2_ba",   32'(bus2.prog_ba),   32'd1);
      check("b2_addr", 32'(bus2.prog_addr), 32'h20_0002);
      rdy_pulse();
      step(3);
      rdy_pulse();
      step(2);

      // Overflow: five bytes with rdy withheld
      for (int i = 0; i < 5; i++) wr_byte(25'h40_0000 + 25'(i), 8'h10 + 8'(i));
      step();
      check("ovf_set", 32'(ovf), 32'd1);
      for (int k = 0; k < 4; k++) begin
         wait_we();
         check("ovf_order", 32'(bus.prog_data), 32'({2{8'h10 + 8'(k)}}));
         rdy_pulse();
      end
      step(4);
      check("ovf_drained", 32'(bus.prog_we), 32'd0);
      downloading = 1'b0;
      step();
      check("ovf_hold", 32'(ovf), 32'd1);
      downloading = 1'b1;
      step();
      check("ovf_clr", 32'(ovf), 32'd0);

      // Drain after downloading falls
      for (int i = 0; i < 3; i++) wr_byte(25'hC0_0100 + 25'(i), 8'h70 + 8'(i));
      downloading = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_we();
         check("drain_busy", 32'(busy), 32'd1);
         rdy_pulse();
      end
      check("gap_busy", 32'(busy), 32'd1);
      step();
      check("idle_busy", 32'(busy), 32'd0);
      step(2);

      // rdy held high: simultaneous push/pop and ignored rdy outside ISSUE
      downloading = 1'b1;
      bus.prog_rdy = 1'b1;
      for (int i = 0; i < 12; i++) begin
         wr_byte(25'h40_0001 + 25'(i * 3), 8'h50 + 8'(i));
         step();
      end
      step(30);
      bus.prog_rdy = 1'b0;
      step(2);

      // Reset in the middle of a request
      for (int i = 0; i < 5; i++) wr_byte(25'h00_0020 + 25'(i), 8'h90 + 8'(i));
      wait_we();
      check("pre_rst_ovf", 32'(ovf), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_we",   32'(bus.prog_we), 32'd0);
      check("arst_ovf",  32'(ovf),         32'd0);
      check("arst_busy", 32'(busy),        32'd1);
      step();
      rst_n = 1'b1;
      step(8);
      check("post_rst_we", 32'(bus.prog_we), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
